// File: rtl/systolic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl_pkg
// Purpose  : Shared FSM encoding, default array geometry and drain length.
// Revision : 1.0
// ============================================================================
package systolic_ctrl_pkg;

    localparam int N_DEFAULT   = 8;
    localparam int A_W_DEFAULT = 8;
    localparam int W_W_DEFAULT = 8;
    localparam int K_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Last operand needs N-1 skew cycles plus N-1 propagation cycles to settle.
    function automatic int drain_cyc(input int n);
        return 2 * (n - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl_skew_line.sv
`default_nettype none
// ============================================================================
// Module   : skew_line
// Purpose  : Fixed-depth lane delay with synchronous flush; depth 0 is a wire.
// Revision : 1.0
// ============================================================================
module skew_line
    import systolic_ctrl_pkg::*;
#(
    parameter int WIDTH = A_W_DEFAULT,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, i_flush};
            assign o_data   = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_sh [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_sh[i] <= '0;
                    end
                end else if (i_flush) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_sh[i] <= '0;
                    end
                end else begin
                    r_sh[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sh[i] <= r_sh[i-1];
                    end
                end
            end

            assign o_data = r_sh[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Purpose  : Clears an NxN systolic array, streams K skewed operand steps,
//            holds enables through drain and pulses done.
// Revision : 1.0
// ============================================================================
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int A_W = A_W_DEFAULT,
    parameter int W_W = W_W_DEFAULT,
    parameter int K_W = K_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [K_W-1:0]   i_k_len,
    input  logic [N-1:0]     i_row_mask,
    input  logic [N-1:0]     i_col_mask,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_act_rd_en,
    output logic [K_W-1:0]   o_act_rd_addr,
    input  logic [N*A_W-1:0] i_act_rd_data,
    output logic             o_wgt_rd_en,
    output logic [K_W-1:0]   o_wgt_rd_addr,
    input  logic [N*W_W-1:0] i_wgt_rd_data,
    output logic             o_arr_clr,
    output logic             o_arr_en,
    output logic [N-1:0]     o_arr_row_en,
    output logic [N-1:0]     o_arr_col_en,
    output logic [N*A_W-1:0] o_activation_in_flat,
    output logic [N*W_W-1:0] o_weight_in_flat
);

    localparam int DRAIN_CYC = drain_cyc(N);
    localparam int DC_W      = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

    state_t           r_state;
    logic [K_W-1:0]   r_k_len;
    logic [N-1:0]     r_row_mask;
    logic [N-1:0]     r_col_mask;
    logic [K_W-1:0]   r_addr;
    logic [DC_W-1:0]  r_drain_cnt;
    logic             r_rd_en;
    logic             r_rd_vld;
    logic             r_clr;
    logic             r_done;
    logic             r_arr_en;
    logic [N-1:0]     r_row_en;
    logic [N-1:0]     r_col_en;

    logic             w_abort;
    logic [N*A_W-1:0] w_act_in;
    logic [N*W_W-1:0] w_wgt_in;

    assign w_abort = i_abort && (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_row_mask  <= '0;
            r_col_mask  <= '0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
            r_rd_en     <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_clr       <= 1'b0;
            r_done      <= 1'b0;
            r_arr_en    <= 1'b0;
            r_row_en    <= '0;
            r_col_en    <= '0;
        end else begin
            r_clr    <= 1'b0;
            r_done   <= 1'b0;
            r_rd_en  <= 1'b0;
            r_rd_vld <= r_rd_en;
            r_arr_en <= 1'b0;
            r_row_en <= '0;
            r_col_en <= '0;

            if (w_abort) begin
                // Read returning next cycle is dropped along with the skew contents.
                r_state  <= S_IDLE;
                r_clr    <= 1'b1;
                r_rd_vld <= 1'b0;
                r_addr   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state    <= S_CLEAR;
                            r_clr      <= 1'b1;
                            r_k_len    <= i_k_len;
                            r_row_mask <= i_row_mask;
                            r_col_mask <= i_col_mask;
                        end
                    end
                    S_CLEAR: begin
                        r_addr <= '0;
                        if (r_k_len != '0) begin
                            r_state <= S_FEED;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    S_FEED: begin
                        // Data requested this cycle lands next cycle, so enable follows.
                        r_arr_en <= 1'b1;
                        r_row_en <= r_row_mask;
                        r_col_en <= r_col_mask;
                        if (r_addr == r_k_len - K_W'(1)) begin
                            r_state     <= S_DRAIN;
                            r_addr      <= '0;
                            r_drain_cnt <= '0;
                        end else begin
                            r_addr  <= r_addr + K_W'(1);
                            r_rd_en <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain_cnt == DC_W'(DRAIN_CYC)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + DC_W'(1);
                            r_arr_en    <= 1'b1;
                            r_row_en    <= r_row_mask;
                            r_col_en    <= r_col_mask;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_act_in = r_rd_vld ? i_act_rd_data : '0;
    assign w_wgt_in = r_rd_vld ? i_wgt_rd_data : '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            skew_line #(
                .WIDTH (A_W),
                .DEPTH (gi)
            ) u_act_skew (
                .clk     (clk),
                .rst     (rst),
                .i_flush (w_abort),
                .i_data  (w_act_in[gi*A_W +: A_W]),
                .o_data  (o_activation_in_flat[gi*A_W +: A_W])
            );

            skew_line #(
                .WIDTH (W_W),
                .DEPTH (gi)
            ) u_wgt_skew (
                .clk     (clk),
                .rst     (rst),
                .i_flush (w_abort),
                .i_data  (w_wgt_in[gi*W_W +: W_W]),
                .o_data  (o_weight_in_flat[gi*W_W +: W_W])
            );
        end
    endgenerate

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_act_rd_en   = r_rd_en;
    assign o_act_rd_addr = r_addr;
    assign o_wgt_rd_en   = r_rd_en;
    assign o_wgt_rd_addr = r_addr;
    assign o_arr_clr     = r_clr;
    assign o_arr_en      = r_arr_en;
    assign o_arr_row_en  = r_row_en;
    assign o_arr_col_en  = r_col_en;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Purpose  : Self-checking bench for systolic_ctrl against a cycle-schedule model.
// Revision : 1.0
// ============================================================================
module tb_systolic_ctrl;

    localparam int N     = 8;
    localparam int A_W   = 8;
    localparam int W_W   = 8;
    localparam int K_W   = 8;
    localparam int DRAIN = 2 * (N - 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start, i_abort;
    logic [K_W-1:0]   i_k_len;
    logic [N-1:0]     i_row_mask, i_col_mask;
    logic             o_busy, o_done;
    logic             o_act_rd_en, o_wgt_rd_en;
    logic [K_W-1:0]   o_act_rd_addr, o_wgt_rd_addr;
    logic [N*A_W-1:0] i_act_rd_data;
    logic [N*W_W-1:0] i_wgt_rd_data;
    logic             o_arr_clr, o_arr_en;
    logic [N-1:0]     o_arr_row_en, o_arr_col_en;
    logic [N*A_W-1:0] o_activation_in_flat;
    logic [N*W_W-1:0] o_weight_in_flat;

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .A_W(A_W), .W_W(W_W), .K_W(K_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_start              (i_start),
        .i_abort              (i_abort),
        .i_k_len              (i_k_len),
        .i_row_mask           (i_row_mask),
        .i_col_mask           (i_col_mask),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_act_rd_en          (o_act_rd_en),
        .o_act_rd_addr        (o_act_rd_addr),
        .i_act_rd_data        (i_act_rd_data),
        .o_wgt_rd_en          (o_wgt_rd_en),
        .o_wgt_rd_addr        (o_wgt_rd_addr),
        .i_wgt_rd_data        (i_wgt_rd_data),
        .o_arr_clr            (o_arr_clr),
        .o_arr_en             (o_arr_en),
        .o_arr_row_en         (o_arr_row_en),
        .o_arr_col_en         (o_arr_col_en),
        .o_activation_in_flat (o_activation_in_flat),
        .o_weight_in_flat     (o_weight_in_flat)
    );

    typedef struct {
        int         k;
        logic [7:0] rm;
        logic [7:0] cm;
        int         pat;
        int         abort_t;
        int         restart_t;
        int         rst_t;
        int         exp_done_t;
        int         exp_en;
    } vec_t;

    vec_t vecs [10];

    int checks   = 0;
    int failures = 0;
    int cur_t    = 0;

    logic [A_W-1:0] amem [256][N];
    logic [W_W-1:0] wmem [256][N];
    logic           prev_rd;
    logic [K_W-1:0] prev_addr;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", nm, cur_t, got, exp);
        end
    endtask

    // Buffer model: one-cycle read latency, junk when no read was issued.
    task automatic tick();
        logic [N*A_W-1:0] a;
        logic [N*W_W-1:0] w;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            a[r*A_W +: A_W] = prev_rd ? amem[prev_addr][r] : A_W'($urandom);
            w[r*W_W +: W_W] = prev_rd ? wmem[prev_addr][r] : W_W'($urandom);
        end
        i_act_rd_data = a;
        i_wgt_rd_data = w;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctrl"}, 64'({o_busy, o_done, o_act_rd_en, o_wgt_rd_en, o_arr_clr, o_arr_en,
                                o_act_rd_addr, o_wgt_rd_addr, o_arr_row_en, o_arr_col_en}), 64'd0);
        chk({nm, "_act_flat"}, 64'(o_activation_in_flat), 64'd0);
        chk({nm, "_wgt_flat"}, 64'(o_weight_in_flat), 64'd0);
    endtask

    task automatic run_job(input int k, input logic [7:0] rm, input logic [7:0] cm, input int pat,
                           input int abort_t, input int restart_t, input int rst_t,
                           output int done_cnt, output int first_done, output int en_cnt);
        int done_t, end_t, idx;
        logic live, e_clr, e_rd, e_en, e_done, e_busy, chk_flat;
        logic [63:0] ea, ew;
        done_t     = (k == 0) ? 2 : k + 3 + DRAIN;
        done_cnt   = 0;
        first_done = 0;
        en_cnt     = 0;
        for (int kk = 0; kk < k; kk++) begin
            for (int r = 0; r < N; r++) begin
                amem[kk][r] = (pat == 1) ? A_W'(r + 1) : A_W'($urandom);
                wmem[kk][r] = W_W'($urandom);
            end
        end
        i_start    = 1'b1;
        i_abort    = (abort_t == 0);
        i_k_len    = K_W'(k);
        i_row_mask = rm;
        i_col_mask = cm;
        tick();
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_k_len    = K_W'($urandom);
        i_row_mask = N'($urandom);
        i_col_mask = N'($urandom);
        end_t = (abort_t >= 1) ? abort_t + 3 : done_t + 2;
        for (int t = 1; t <= end_t; t++) begin
            if (t == abort_t)   i_abort = 1'b1;
            if (t == restart_t) i_start = 1'b1;
            @(negedge clk);
            cur_t = t;
            live  = (abort_t < 1) || (t <= abort_t);
            if (live) begin
                e_clr    = (t == 1);
                e_rd     = (k > 0) && (t >= 2) && (t <= k + 1);
                e_en     = (k > 0) && (t >= 3) && (t <= k + 2 + DRAIN);
                e_done   = (t == done_t);
                e_busy   = (t <= done_t);
                chk_flat = 1'b1;
            end else begin
                e_clr    = (t == abort_t + 1);
                e_rd     = 1'b0;
                e_en     = 1'b0;
                e_done   = 1'b0;
                e_busy   = 1'b0;
                chk_flat = (t >= abort_t + 2);
            end
            for (int r = 0; r < N; r++) begin
                idx = t - 3 - r;
                ea[r*8 +: 8] = (live && idx >= 0 && idx < k) ? amem[idx][r] : 8'd0;
                ew[r*8 +: 8] = (live && idx >= 0 && idx < k) ? wmem[idx][r] : 8'd0;
            end
            chk("busy", 64'(o_busy), 64'(e_busy));
            chk("done", 64'(o_done), 64'(e_done));
            chk("arr_clr", 64'(o_arr_clr), 64'(e_clr));
            chk("act_rd_en", 64'(o_act_rd_en), 64'(e_rd));
            chk("wgt_rd_en", 64'(o_wgt_rd_en), 64'(e_rd));
            if (e_rd) begin
                chk("act_rd_addr", 64'(o_act_rd_addr), 64'(t - 2));
                chk("wgt_rd_addr", 64'(o_wgt_rd_addr), 64'(t - 2));
            end
            chk("arr_en", 64'(o_arr_en), 64'(e_en));
            chk("arr_row_en", 64'(o_arr_row_en), e_en ? 64'(rm) : 64'd0);
            chk("arr_col_en", 64'(o_arr_col_en), e_en ? 64'(cm) : 64'd0);
            if (chk_flat) begin
                chk("act_flat", 64'(o_activation_in_flat), ea);
                chk("wgt_flat", 64'(o_weight_in_flat), ew);
            end
            if (o_done) begin
                done_cnt++;
                if (first_done == 0) first_done = t;
            end
            if (o_arr_en) en_cnt++;
            prev_rd   = o_act_rd_en;
            prev_addr = o_act_rd_addr;
            if (t == rst_t) begin
                #1 rst = 1'b1;
                #1;
                chk_all_zero("async_rst");
                prev_rd = 1'b0;
                @(posedge clk);
                #1;
                rst     = 1'b0;
                i_start = 1'b0;
                i_abort = 1'b0;
                break;
            end
            tick();
            i_abort = 1'b0;
            i_start = 1'b0;
        end
    endtask

    initial begin
        int dc, fd, ec, kr, dt, ab, rs;
        logic [7:0] rmr, cmr;

        rst           = 1'b1;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_k_len       = '0;
        i_row_mask    = '0;
        i_col_mask    = '0;
        i_act_rd_data = '1;
        i_wgt_rd_data = '1;
        prev_rd       = 1'b0;
        prev_addr     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        i_abort = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_abort_busy", 64'(o_busy), 64'd0);
            chk("idle_abort_clr", 64'(o_arr_clr), 64'd0);
            tick();
        end
        i_abort = 1'b0;

        //            k    rm      cm    pat abort restart rst done  en
        vecs[0] = '{  4, 8'hFF, 8'hFF, 1,  -1,   -1,   -1,  21,  18};
        vecs[1] = '{  0, 8'hFF, 8'hFF, 0,  -1,   -1,   -1,   2,   0};
        vecs[2] = '{  2, 8'h0F, 8'hF0, 0,  -1,   -1,   -1,  19,  16};
        vecs[3] = '{  8, 8'hFF, 8'hFF, 0,   6,   -1,   -1,   0,   4};
        vecs[4] = '{  3, 8'hFF, 8'hFF, 0,  -1,    5,   -1,  20,  17};
        vecs[5] = '{  4, 8'hFF, 8'hFF, 0,  -1,   -1,   12,   0,  10};
        vecs[6] = '{  1, 8'hFF, 8'hFF, 0,  -1,   -1,   -1,  18,  15};
        vecs[7] = '{  2, 8'h3C, 8'hC3, 0,   0,   -1,   -1,  19,  16};
        vecs[8] = '{255, 8'hA5, 8'h5A, 0,  -1,   -1,   -1, 272, 269};
        vecs[9] = '{  5, 8'hFF, 8'hFF, 0,   1,   -1,   -1,   0,   0};

        for (int v = 0; v < 10; v++) begin
            run_job(vecs[v].k, vecs[v].rm, vecs[v].cm, vecs[v].pat, vecs[v].abort_t,
                    vecs[v].restart_t, vecs[v].rst_t, dc, fd, ec);
            cur_t = v;
            chk("vec_done_count", 64'(dc), (vecs[v].exp_done_t > 0) ? 64'd1 : 64'd0);
            chk("vec_done_cycle", 64'(fd), 64'(vecs[v].exp_done_t));
            chk("vec_en_cycles", 64'(ec), 64'(vecs[v].exp_en));
        end

        for (int j = 0; j < 25; j++) begin
            kr  = int'($urandom_range(20, 0));
            rmr = 8'($urandom);
            cmr = 8'($urandom);
            dt  = (kr == 0) ? 2 : kr + 3 + DRAIN;
            ab  = -1;
            rs  = -1;
            if ($urandom_range(3, 0) == 0) ab = int'($urandom_range(dt, 1));
            else if ($urandom_range(3, 0) == 0) rs = int'($urandom_range(dt, 1));
            run_job(kr, rmr, cmr, 0, ab, rs, -1, dc, fd, ec);
            cur_t = j;
            chk("rand_done_count", 64'(dc), (ab < 1 || ab >= dt) ? 64'd1 : 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for the 8x8 systolic array. On a start command it clears the array and streams K reduction steps of activations and weights from two operand buffers. Each row and column lane is diagonally skewed before it drives the array's left and top edges. The block holds `en`, `row_en` and `col_en` through the drain window, then pulses `done` when the array results are final.

Parameters:
- N, 8, array dimension (rows = cols)
- A_W, 8, activation width
- W_W, 8, weight width
- K_W, 8, width of the reduction-length field and the buffer address
- DRAIN_CYC, 2*(N-1), extra en cycles after the last operand enters the skew (localparam)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  start request; sampled only in IDLE
- abort  in  1  cancel the current operation
- k_len  in  K_W  reduction length; latched on start
- row_mask  in  N  enabled rows; latched on start
- col_mask  in  N  enabled cols; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- act_rd_en  out  1  activation buffer read strobe
- act_rd_addr  out  K_W  activation buffer address (step k)
- act_rd_data  in  N*A_W  A[r][k] for all r; row r at bits [r*A_W+:A_W]; valid 1 cycle after strobe
- wgt_rd_en  out  1  weight buffer read strobe (same timing as act)
- wgt_rd_addr  out  K_W  weight buffer address
- wgt_rd_data  in  N*W_W  W[k][c] for all c; col c at bits [c*W_W+:W_W]; valid 1 cycle after strobe
- arr_clr  out  1  clear pulse to the array reset
- arr_en  out  1  array enable
- arr_row_en  out  N  array row enables
- arr_col_en  out  N  array column enables
- activation_in_flat  out  N*A_W  skewed left-edge activations
- weight_in_flat  out  N*W_W  skewed top-edge weights

Behaviour:
- Reset (async): state = IDLE. All outputs 0. Skew registers 0. Latched config 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE -> CLEAR when start=1.
  - CLEAR lasts 1 cycle, arr_clr=1. Then go to FEED if k_len!=0, else DONE.
  - FEED lasts k_len cycles. act_rd_en = wgt_rd_en = 1. Both addresses = step counter 0..k_len-1. Then go to DRAIN.
  - DRAIN lasts 1+DRAIN_CYC cycles. Then go to DONE.
  - DONE lasts 1 cycle, done=1. Then go to IDLE.
- Timing with start sampled at cycle 0: CLEAR at 1, FEED at 2..K+1, data valid at 3..K+2, arr_en high at 3..K+2+2(N-1), done at K+3+2(N-1).
- Skew:
  - Row lane r = act_rd_data row r delayed r cycles; lane 0 has zero delay.
  - Column lane c = wgt_rd_data col c delayed c cycles; lane 0 has zero delay.
  - When read data is not valid, zeros enter the skew. The flat outputs are therefore 0 outside valid windows.
- arr_row_en / arr_col_en = latched masks while arr_en=1, else 0.
- arr_en: 1 from the first data-valid cycle through the end of DRAIN.
- abort: valid in any non-IDLE state. Next cycle: state = IDLE, arr_clr=1 for 1 cycle, skew flushed to 0, done not asserted.
- start while busy: ignored. abort in IDLE: ignored. start and abort together in IDLE: start wins.
- k_len max = 2^K_W-1. The step counter never wraps within a job.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Pending reads are discarded.

Decomposition:
- Shared package holds the FSM state encoding, the default N/A_W/W_W/K_W values, and the DRAIN_CYC formula.
- One sub-module, skew_line: parameterised lane width and depth (depth 0 = wire), with a sync flush input. It is instantiated 2*N times in a generate loop.

Test Plan:
- K=4, full masks, act row r = r+1 on every step -> arr_clr at cycle 1; reads at addr 0..3 in cycles 2..5; activation lane 7 first nonzero at cycle 10; arr_en high cycles 3..20; done at cycle 21 only.
- K=0 -> CLEAR at cycle 1, DONE at cycle 2, no read strobes, arr_en never high.
- row_mask=8'h0F, col_mask=8'hF0, K=2 -> arr_row_en=0x0F and arr_col_en=0xF0 exactly while arr_en=1; both 0 otherwise.
- abort at cycle 6 of a K=8 job -> IDLE at cycle 7, arr_clr=1 at cycle 7, flat outputs 0 from cycle 8, no done pulse.
- start asserted while busy at cycle 5 -> ignored; done count = 1; a new start after done runs a normal job.
- rst asserted mid-DRAIN -> all outputs 0 asynchronously; a later start with K=1 gives done at cycle 18.
